nrz_tx_driver: RTL and testbench
================================

# nrz_tx_driver

Clocked transmit driver that feeds the channel filter model. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per clock (one UI). Each bit drives a real-valued NRZ level with optional 2-tap de-emphasis. Its `out` connects directly to the `in` of the downstream RC channel filter.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `AMP`, 1.0 (real): NRZ amplitude in volts; symbol levels are ±AMP.
- `DEEMPH`, 0.0 (real): post-cursor de-emphasis coefficient; legal range 0.0..0.5.
- `clk`  input  1  bit clock; one rising edge equals one UI.
- `rst_n`  input  1  asynchronous, active-low reset.
- `data_in`  input  WIDTH  word to transmit.
- `data_valid`  input  1  `data_in` is valid.
- `data_ready`  output  1  holding register can accept a word.
- `busy`  output  1  a word is being shifted out, or the holding register is full.
- `out`  output  real  analog drive level to the channel.

## Operation
- Storage: one holding register (`hold`, `hold_full`), one shift register (`shreg`), bit counter `bit_idx` (0..WIDTH-1), and a previous symbol `prev_s` (real: -1.0, 0.0 or +1.0).
- States:
  - **IDLE**: shifter empty; `out` = 0.0 (electrical idle); `prev_s` = 0.0.
  - **SHIFT**: a word is in the shifter.
- Accept: on a rising edge with `data_valid && data_ready`, the word is written into `hold` and `hold_full` is set.
  - `data_ready` = !`hold_full`.
  - When `data_valid` is high and `data_ready` is low, the word is not taken. The source holds it.
- Load into the shifter (hold → shreg, `hold_full` cleared, `bit_idx` = 0) happens on an edge where `hold_full` = 1 and either:
  - the state is IDLE, or
  - the state is SHIFT with `bit_idx` = WIDTH-1.
  The new word's MSB is driven on that same edge.
- Shift: in SHIFT with `bit_idx` < WIDTH-1, each edge advances `bit_idx` and drives the next bit.
- End of word: at `bit_idx` = WIDTH-1 with `hold_full` = 0, the next edge enters IDLE, sets `out` = 0.0 and clears `prev_s` to 0.0.
- Symbol mapping: bit 1 → s = +1.0; bit 0 → s = -1.0.
- Drive level: `out` = AMP*(s - DEEMPH*prev_s), updated on the edge that presents the bit. `prev_s` then takes the value s.
- `busy` = (state == SHIFT) || `hold_full`.
- Accept and load on the same edge: when `hold` is being loaded into `shreg`, `data_ready` is already low, so no new word is accepted that edge. The freed slot shows `data_ready` = 1 from the following cycle.
- Reset (asserted asynchronously at any time, including mid-word):
  - state → IDLE, `hold_full` = 0, `bit_idx` = 0, `prev_s` = 0.0, `out` = 0.0 immediately.
  - Outputs: `data_ready` = 1, `busy` = 0.
  - In-flight and held words are discarded.
  - Deassertion takes effect at the next rising edge.

## Timing
- Latency: word accepted at edge k from IDLE → MSB on `out` after edge k+1 → LSB after edge k+WIDTH.
- Throughput: back-to-back words with no idle UI, provided the source presents the next word any time before the current word's last bit. Sustained rate is one bit per clock.
- `out` changes only on rising `clk` edges or on reset assertion. It is held constant between edges, so the downstream filter sees one step per UI.
- `data_ready` and `busy` are decoded from registered state only. There is no combinational path from `data_valid` to `data_ready`.

## Test plan
- **Reset values**: assert `rst_n` = 0 → `out` = 0.0, `data_ready` = 1, `busy` = 0. Release, hold `data_valid` = 0 for 20 cycles → `out` stays 0.0.
- **Single word, no de-emphasis**: WIDTH=8, AMP=1.0, DEEMPH=0.0; send 0xA5 → `out` = +1,-1,+1,-1,-1,+1,-1,+1 on edges k+1..k+8, then 0.0 on edge k+9, `busy` falls on the same edge.
- **De-emphasis**: DEEMPH=0.25, send 0xA5 from IDLE → `out` = 1.0, -1.25, 1.25, -1.25, -0.75, 1.25, -1.25, 1.25, then 0.0.
- **Back-to-back**: send 0xFF then 0x00 with `data_valid` held high → 16 consecutive UIs with no 0.0 gap. With DEEMPH=0.25: first +1.0, then +0.75 ×7, then -1.25, then -0.75 ×7. `data_ready` is low during the cycles when `hold_full` is set.
- **Backpressure**: hold `data_valid` high with three distinct words → each is accepted exactly once, in order. No word is dropped or duplicated, checked against the serial bit stream.
- **Mid-word reset**: assert `rst_n` low after the third bit of 0xC3 with 0x3C held → `out` = 0.0 immediately. After release and one new word 0x81, only 0x81's bits appear, with the first level at +AMP (`prev_s` was cleared).

Source files
------------

// File: rtl/nrz_tx_driver_if.sv
// Word handshake between a parallel data source and nrz_tx_driver.
interface nrz_tx_driver_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/nrz_tx_driver.sv
// NRZ transmit driver: one holding register feeding an MSB-first shifter,
// one bit per clock, with real-valued 2-tap de-emphasised drive level.
module nrz_tx_driver #(
   parameter int  WIDTH  = 8,
   parameter real AMP    = 1.0,
   parameter real DEEMPH = 0.0
) (
   input  logic             clk,
   input  logic             rst_n,
   nrz_tx_driver_if.slave   bus,
   output logic             busy,
   output real              out
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [WIDTH-1:0] shreg;
   logic [IW-1:0]    bit_idx;
   real              prev_s;

   logic             last_bit;
   logic             load;
   logic             accept;
   logic             shift_adv;
   logic             cur_bit;
   real              cur_s;
   real              level;

   // Control decode and next drive level from registered state.
   // The shifter is shifted left after each bit, so the bit following the
   // one just presented always sits at shreg[WIDTH-2].
   always_comb begin
      last_bit  = (bit_idx == LAST_IDX);
      load      = hold_full && ((state_q == IDLE) || last_bit);
      accept    = bus.data_valid && !hold_full;
      shift_adv = (state_q == SHIFT) && !last_bit;
      cur_bit   = load ? hold[WIDTH-1] : shreg[WIDTH-2];
      cur_s     = cur_bit ? 1.0 : -1.0;
      level     = AMP * (cur_s - DEEMPH * prev_s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a pending load keeps (or starts) shifting, otherwise the
   // word's last bit returns the driver to idle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (last_bit && !load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs, decoded from registers only.
   always_comb begin
      bus.data_ready = !hold_full;
      busy           = (state_q == SHIFT) || hold_full;
   end

   // Holding register, shifter, bit counter and drive level.
   // Accept and load are mutually exclusive (accept needs an empty holding
   // register, load needs a full one), so both may share one process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
         shreg     <= '0;
         bit_idx   <= '0;
         prev_s    <= 0.0;
         out       <= 0.0;
      end else begin
         if (accept) begin
            hold      <= bus.data_in;
            hold_full <= 1'b1;
         end
         if (load) begin
            shreg     <= hold;
            hold_full <= 1'b0;
            bit_idx   <= '0;
            out       <= level;
            prev_s    <= cur_s;
         end else if (shift_adv) begin
            shreg   <= shreg << 1;
            bit_idx <= bit_idx + IW'(1);
            out     <= level;
            prev_s  <= cur_s;
         end else if (state_q == SHIFT) begin
            out    <= 0.0;
            prev_s <= 0.0;
         end
      end
   end
endmodule

// File: tb/tb_nrz_tx_driver.sv
// Directed bench for nrz_tx_driver: two instances (no de-emphasis and
// DEEMPH=0.25) receive identical stimulus; levels are expected in quarter volts.
module tb_nrz_tx_driver;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic busy0, busy1;
   real  out0, out1;

   int total = 0;
   int bad   = 0;

   nrz_tx_driver_if #(.WIDTH(8)) bus0 ();
   nrz_tx_driver_if #(.WIDTH(8)) bus1 ();

   nrz_tx_driver #(.WIDTH(8), .AMP(1.0), .DEEMPH(0.0)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .busy(busy0), .out(out0)
   );
   nrz_tx_driver #(.WIDTH(8), .AMP(1.0), .DEEMPH(0.25)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1), .out(out1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              v;
      logic [7:0]        d;
      logic signed [7:0] e0;
      logic signed [7:0] e1;
      logic              er;
      logic              eb;
   } vec_t;

   localparam int NVEC = 28;
   vec_t tbl [0:NVEC-1];

   logic [7:0] words [0:2];

   function automatic vec_t mk(logic v, logic [7:0] d, int e0, int e1, logic er, logic eb);
      vec_t r;
      r.v  = v;
      r.d  = d;
      r.e0 = 8'(e0);
      r.e1 = 8'(e1);
      r.er = er;
      r.eb = eb;
      return r;
   endfunction

   task automatic set_in(input logic v, input logic [7:0] d);
      bus0.data_valid = v;
      bus0.data_in    = d;
      bus1.data_valid = v;
      bus1.data_in    = d;
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      set_in(v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_lvl(input string n, input real act, input int q);
      real diff;
      total++;
      diff = act * 4.0 - real'(q);
      if (diff > 1.0e-6 || diff < -1.0e-6) begin
         bad++;
         $display("FAIL %s: got %f want %f", n, act, real'(q) / 4.0);
      end
   endtask

   task automatic chk_bit(input string n, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", n, act, exp);
      end
   endtask

   task automatic chk_int(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", n, act, exp);
      end
   endtask

   initial begin
      int         w;
      int         nb;
      logic [23:0] stream;
      logic       rdy;
      logic       vv;
      int         e81_0 [0:7];
      int         e81_1 [0:7];

      // 0xA5 from idle
      tbl[0]  = mk(1'b1, 8'hA5,  0,  0, 1'b0, 1'b1);
      tbl[1]  = mk(1'b0, 8'h00,  4,  4, 1'b1, 1'b1);
      tbl[2]  = mk(1'b0, 8'h00, -4, -5, 1'b1, 1'b1);
      tbl[3]  = mk(1'b0, 8'h00,  4,  5, 1'b1, 1'b1);
      tbl[4]  = mk(1'b0, 8'h00, -4, -5, 1'b1, 1'b1);
      tbl[5]  = mk(1'b0, 8'h00, -4, -3, 1'b1, 1'b1);
      tbl[6]  = mk(1'b0, 8'h00,  4,  5, 1'b1, 1'b1);
      tbl[7]  = mk(1'b0, 8'h00, -4, -5, 1'b1, 1'b1);
      tbl[8]  = mk(1'b0, 8'h00,  4,  5, 1'b1, 1'b1);
      tbl[9]  = mk(1'b0, 8'h00,  0,  0, 1'b1, 1'b0);
      // 0xFF then 0x00 back-to-back
      tbl[10] = mk(1'b1, 8'hFF,  0,  0, 1'b0, 1'b1);
      tbl[11] = mk(1'b1, 8'h00,  4,  4, 1'b1, 1'b1);
      tbl[12] = mk(1'b1, 8'h00,  4,  3, 1'b0, 1'b1);
      for (int i = 13; i <= 18; i++) tbl[i] = mk(1'b0, 8'h00, 4, 3, 1'b0, 1'b1);
      tbl[19] = mk(1'b0, 8'h00, -4, -5, 1'b1, 1'b1);
      for (int i = 20; i <= 26; i++) tbl[i] = mk(1'b0, 8'h00, -4, -3, 1'b1, 1'b1);
      tbl[27] = mk(1'b0, 8'h00,  0,  0, 1'b1, 1'b0);

      words[0] = 8'h5A;
      words[1] = 8'h3C;
      words[2] = 8'hE1;

      e81_0 = '{4, -4, -4, -4, -4, -4, -4, 4};
      e81_1 = '{4, -5, -3, -3, -3, -3, -3, 5};

      set_in(1'b0, 8'h00);

      // Reset values
      #3 rst_n = 1'b0;
      #2;
      chk_lvl("rst out0", out0, 0);
      chk_lvl("rst out1", out1, 0);
      chk_bit("rst ready0", bus0.data_ready, 1'b1);
      chk_bit("rst ready1", bus1.data_ready, 1'b1);
      chk_bit("rst busy0", busy0, 1'b0);
      chk_bit("rst busy1", busy1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(1'b0, 8'h00);
         chk_lvl($sformatf("idle%0d out1", i), out1, 0);
      end

      // Table: single word and back-to-back
      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].v, tbl[i].d);
         chk_lvl($sformatf("tbl%0d out0", i), out0, int'(tbl[i].e0));
         chk_lvl($sformatf("tbl%0d out1", i), out1, int'(tbl[i].e1));
         chk_bit($sformatf("tbl%0d ready", i), bus0.data_ready, tbl[i].er);
         chk_bit($sformatf("tbl%0d busy", i), busy0, tbl[i].eb);
         chk_bit($sformatf("tbl%0d busy1", i), busy1, tbl[i].eb);
      end

      // Mid-word reset: 0xC3 shifting, 0x3C held
      step(1'b1, 8'hC3);
      step(1'b0, 8'h00);
      step(1'b1, 8'h3C);
      step(1'b1, 8'h3C);
      chk_lvl("c3 bit3 out0", out0, -4);
      chk_lvl("c3 bit3 out1", out1, -5);
      chk_bit("c3 held ready", bus0.data_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_lvl("midrst out0", out0, 0);
      chk_lvl("midrst out1", out1, 0);
      chk_bit("midrst ready", bus0.data_ready, 1'b1);
      chk_bit("midrst busy", busy0, 1'b0);
      set_in(1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h81);
      chk_lvl("81 acc out0", out0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00);
         chk_lvl($sformatf("81 b%0d out0", i), out0, e81_0[i]);
         chk_lvl($sformatf("81 b%0d out1", i), out1, e81_1[i]);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00);
         chk_lvl($sformatf("81 tail%0d out0", i), out0, 0);
         chk_bit($sformatf("81 tail%0d busy", i), busy0, 1'b0);
      end

      // Backpressure: valid held high across three words
      w = 0;
      nb = 0;
      stream = '0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         vv = (w < 3);
         set_in(vv, vv ? words[w] : 8'h00);
         rdy = bus0.data_ready;
         @(posedge clk);
         #1;
         if (vv && rdy) w++;
         if (out0 > 0.5) begin
            stream = {stream[22:0], 1'b1};
            nb++;
         end else if (out0 < -0.5) begin
            stream = {stream[22:0], 1'b0};
            nb++;
         end
      end
      chk_int("bp accepted", w, 3);
      chk_int("bp bits", nb, 24);
      chk_int("bp word0", int'(stream[23:16]), 32'h5A);
      chk_int("bp word1", int'(stream[15:8]), 32'h3C);
      chk_int("bp word2", int'(stream[7:0]), 32'hE1);
      chk_bit("bp end busy", busy0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
